// File: rtl/itch_message_dispatcher_pkg.sv
// Shared definitions for the ITCH framing front end: type codes, the minimum
// legal length field, the walker state encoding and the start-strobe vector.
package itch_pkg;

    // Smallest legal length-field value (type byte plus a minimal body).
    localparam int MIN_LEN_DEFAULT = 9;

    // Type bytes that have a dedicated downstream parser.
    localparam logic [7:0] TYPE_ORDER_BOOK = 8'h4F;  // 'O'
    localparam logic [7:0] TYPE_ADD        = 8'h41;  // 'A'
    localparam logic [7:0] TYPE_EXECUTED   = 8'h45;  // 'E'
    localparam logic [7:0] TYPE_DELETE     = 8'h44;  // 'D'

    // Byte-walker state.
    typedef enum logic [1:0] {
        HDR  = 2'd0,
        BODY = 2'd1,
        ERR  = 2'd2
    } disp_state_e;

    // One-hot start vector, one bit per downstream parser.
    typedef struct packed {
        logic order_book;
        logic add;
        logic executed;
        logic del;
        logic other;
    } start_vec_t;

endpackage

// File: rtl/itch_message_dispatcher_if.sv
// Stream-side and parser-side signals of the dispatcher. The slave modport is
// the dispatcher itself; the master modport is whoever feeds the stream and
// observes the strobes.
interface itch_message_dispatcher_if;

    logic [63:0] dataIn;
    logic        dataValid;
    logic [63:0] dataOut;
    logic        dataOutValid;
    logic        startOrderBookState;
    logic        startAddOrder;
    logic        startExecuted;
    logic        startDelete;
    logic        startOther;
    logic [5:0]  trackerOut;
    logic [7:0]  msgType;
    logic [15:0] msgLength;
    logic [31:0] msgCount;
    logic        errLength;

    modport master (
        output dataIn, dataValid,
        input  dataOut, dataOutValid,
        input  startOrderBookState, startAddOrder, startExecuted, startDelete, startOther,
        input  trackerOut, msgType, msgLength, msgCount, errLength
    );

    modport slave (
        input  dataIn, dataValid,
        output dataOut, dataOutValid,
        output startOrderBookState, startAddOrder, startExecuted, startDelete, startOther,
        output trackerOut, msgType, msgLength, msgCount, errLength
    );

endinterface

// File: rtl/itch_message_dispatcher_type_decoder.sv
// Combinational map from an ITCH type byte to a one-hot parser start vector.
// Anything without a dedicated parser goes to the "other" parser.
module itch_type_decoder
    import itch_pkg::*;
(
    input  logic [7:0] type_i,
    output start_vec_t start_o
);

    // Pick exactly one parser for the given type byte.
    always_comb begin
        start_o = '0;
        unique case (type_i)
            TYPE_ORDER_BOOK: start_o.order_book = 1'b1;
            TYPE_ADD:        start_o.add        = 1'b1;
            TYPE_EXECUTED:   start_o.executed   = 1'b1;
            TYPE_DELETE:     start_o.del        = 1'b1;
            default:         start_o.other      = 1'b1;
        endcase
    end

endmodule

// File: rtl/itch_message_dispatcher.sv
// Framing stage for a back-to-back stream of length-prefixed ITCH messages.
// Walks all eight bytes of each accepted word in one cycle, tracks the 2-byte
// length prefix and type byte (which may straddle a word boundary), skips the
// body, and fires a start strobe aligned with the one-word-delayed copy of the
// word that holds the first body byte.
module itch_message_dispatcher
    import itch_pkg::*;
#(
    parameter int MIN_LEN = MIN_LEN_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    itch_message_dispatcher_if.slave    bus
);

    // Walker state. pend_q marks a type byte taken at byte 7: its body starts
    // at byte 0 of the next accepted word, so the strobe rides with that word.
    disp_state_e st_q, st_d;
    logic [1:0]  hdrCnt_q, hdrCnt_d;
    logic [7:0]  lenHi_q, lenHi_d;
    logic [15:0] len_q, len_d;
    logic [15:0] bytesLeft_q, bytesLeft_d;
    logic        pend_q, pend_d;
    logic [7:0]  pendType_q, pendType_d;

    // Output registers.
    logic [63:0] dataOut_q;
    logic        dataOutValid_q;
    start_vec_t  strobe_q;
    logic [5:0]  tracker_q;
    logic [7:0]  msgType_q;
    logic [15:0] msgLength_q;
    logic [31:0] msgCount_q;
    logic        errLength_q;

    // Per-word results of the byte walk.
    logic        fire;
    logic [7:0]  fireType;
    logic [15:0] fireLen;
    logic [5:0]  fireTrk;
    logic [7:0]  byte_v;
    start_vec_t  startVec;

    // Walk the eight bytes of the current word in stream order. L >= MIN_LEN
    // guarantees at most one body start per word, so a single fire slot is
    // enough.
    always_comb begin
        st_d        = st_q;
        hdrCnt_d    = hdrCnt_q;
        lenHi_d     = lenHi_q;
        len_d       = len_q;
        bytesLeft_d = bytesLeft_q;
        pend_d      = 1'b0;
        pendType_d  = pendType_q;
        fire        = 1'b0;
        fireType    = pendType_q;
        fireLen     = len_q;
        fireTrk     = '0;
        byte_v      = '0;

        // Body of the message whose type byte closed the previous word
        // starts right here at byte 0.
        if (pend_q) begin
            fire = 1'b1;
        end

        for (int k = 0; k < 8; k++) begin
            byte_v = bus.dataIn[8*k +: 8];
            unique case (st_d)
                HDR: begin
                    if (hdrCnt_d == 2'd0) begin
                        lenHi_d  = byte_v;
                        hdrCnt_d = 2'd1;
                    end else if (hdrCnt_d == 2'd1) begin
                        len_d    = {lenHi_d, byte_v};
                        hdrCnt_d = 2'd2;
                        if ({lenHi_d, byte_v} < 16'(MIN_LEN)) begin
                            st_d     = ERR;
                            hdrCnt_d = 2'd0;
                        end
                    end else begin
                        // Type byte: body follows immediately.
                        hdrCnt_d    = 2'd0;
                        bytesLeft_d = len_d - 16'd1;
                        st_d        = BODY;
                        if (k == 7) begin
                            pend_d     = 1'b1;
                            pendType_d = byte_v;
                        end else begin
                            fire     = 1'b1;
                            fireType = byte_v;
                            fireLen  = len_d;
                            fireTrk  = 6'((k + 1) * 8);
                        end
                    end
                end
                BODY: begin
                    bytesLeft_d = bytesLeft_d - 16'd1;
                    if (bytesLeft_d == 16'd0) begin
                        st_d = HDR;
                    end
                end
                default: begin
                    // Framing lost: ignore everything until reset.
                end
            endcase
        end
    end

    itch_type_decoder u_type_decoder (
        .type_i  (fireType),
        .start_o (startVec)
    );

    // Advance the walker only on accepted words; idle cycles hold everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= HDR;
            hdrCnt_q    <= '0;
            lenHi_q     <= '0;
            len_q       <= '0;
            bytesLeft_q <= '0;
            pend_q      <= 1'b0;
            pendType_q  <= '0;
        end else if (bus.dataValid) begin
            st_q        <= st_d;
            hdrCnt_q    <= hdrCnt_d;
            lenHi_q     <= lenHi_d;
            len_q       <= len_d;
            bytesLeft_q <= bytesLeft_d;
            pend_q      <= pend_d;
            pendType_q  <= pendType_d;
        end
    end

    // Delayed data plus strobe/metadata registers, all updated together.
    always_ff @(posedge clk) begin
        if (rst) begin
            dataOut_q      <= '0;
            dataOutValid_q <= 1'b0;
            strobe_q       <= '0;
            tracker_q      <= '0;
            msgType_q      <= '0;
            msgLength_q    <= '0;
            msgCount_q     <= '0;
            errLength_q    <= 1'b0;
        end else begin
            dataOutValid_q <= bus.dataValid;
            strobe_q       <= '0;
            if (bus.dataValid) begin
                dataOut_q <= bus.dataIn;
                if (st_d == ERR) begin
                    errLength_q <= 1'b1;
                end
                if (fire) begin
                    strobe_q    <= startVec;
                    tracker_q   <= fireTrk;
                    msgType_q   <= fireType;
                    msgLength_q <= fireLen;
                    msgCount_q  <= msgCount_q + 32'd1;
                end
            end
        end
    end

    assign bus.dataOut             = dataOut_q;
    assign bus.dataOutValid        = dataOutValid_q;
    assign bus.startOrderBookState = strobe_q.order_book;
    assign bus.startAddOrder       = strobe_q.add;
    assign bus.startExecuted       = strobe_q.executed;
    assign bus.startDelete         = strobe_q.del;
    assign bus.startOther          = strobe_q.other;
    assign bus.trackerOut          = tracker_q;
    assign bus.msgType             = msgType_q;
    assign bus.msgLength           = msgLength_q;
    assign bus.msgCount            = msgCount_q;
    assign bus.errLength           = errLength_q;

endmodule

// File: tb/tb_itch_message_dispatcher.sv
// Directed bench for itch_message_dispatcher: a hand-laid stream of eight
// messages covering split headers, a body ending on byte 7, a type byte on
// byte 7, an unknown type, idle gaps and a short length, followed by reset
// recovery and a reset that drops a pending strobe.
module tb_itch_message_dispatcher;

    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_OB   = 5'b10000;
    localparam logic [4:0] S_ADD  = 5'b01000;
    localparam logic [4:0] S_EXE  = 5'b00100;
    localparam logic [4:0] S_DEL  = 5'b00010;
    localparam logic [4:0] S_OTH  = 5'b00001;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    logic [7:0]  sb [144];
    logic [63:0] wd [18];
    int          n;

    itch_message_dispatcher_if bus ();

    itch_message_dispatcher dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, then sample 1 time unit after the edge.
    task automatic step(input logic [63:0] w, input logic v);
        bus.dataIn    = w;
        bus.dataValid = v;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] strobes();
        return {bus.startOrderBookState, bus.startAddOrder, bus.startExecuted,
                bus.startDelete, bus.startOther};
    endfunction

    // Send stream word w and check the delayed copy, strobe and tracker.
    task automatic word(input int w, input logic [4:0] es, input logic [5:0] et);
        step(wd[w], 1'b1);
        chk($sformatf("w%0d dataOut", w), bus.dataOut, wd[w]);
        chk($sformatf("w%0d dataOutValid", w), 64'(bus.dataOutValid), 64'd1);
        chk($sformatf("w%0d strobes", w), 64'(strobes()), 64'(es));
        chk($sformatf("w%0d trackerOut", w), 64'(bus.trackerOut), 64'(et));
    endtask

    task automatic meta(input string tag, input logic [7:0] t, input logic [15:0] l, input logic [31:0] c);
        chk({tag, " msgType"}, 64'(bus.msgType), 64'(t));
        chk({tag, " msgLength"}, 64'(bus.msgLength), 64'(l));
        chk({tag, " msgCount"}, 64'(bus.msgCount), 64'(c));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " dataOut"}, bus.dataOut, 64'd0);
        chk({tag, " dataOutValid"}, 64'(bus.dataOutValid), 64'd0);
        chk({tag, " strobes"}, 64'(strobes()), 64'(S_NONE));
        chk({tag, " trackerOut"}, 64'(bus.trackerOut), 64'd0);
        chk({tag, " errLength"}, 64'(bus.errLength), 64'd0);
        meta(tag, 8'h00, 16'd0, 32'd0);
    endtask

    task automatic put_msg(input logic [15:0] l, input logic [7:0] t);
        sb[n] = l[15:8];
        sb[n+1] = l[7:0];
        sb[n+2] = t;
        n = n + 3;
        for (int i = 1; i < int'(l); i++) begin
            sb[n] = 8'(n * 3 + 1);
            n++;
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        n             = 0;
        rst           = 1'b1;
        bus.dataIn    = '0;
        bus.dataValid = 1'b0;

        // Stream layout (byte offsets): msg1 0..30, msg2 31..44, msg3 45..55,
        // msg4 56..69, msg5 70..85, msg6 86..96, msg7 97..118, msg8 119.. (L=5)
        put_msg(16'd29, 8'h4F);
        put_msg(16'd12, 8'h41);
        put_msg(16'd9,  8'h44);
        put_msg(16'd12, 8'h58);
        put_msg(16'd14, 8'h45);
        put_msg(16'd9,  8'h41);
        put_msg(16'd20, 8'h4F);
        put_msg(16'd5,  8'h41);
        while (n < 144) begin
            sb[n] = 8'h41;
            n++;
        end
        for (int w = 0; w < 18; w++)
            for (int k = 0; k < 8; k++)
                wd[w][8*k +: 8] = sb[8*w + k];

        step(64'd0, 1'b0);
        step(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        chk_reset("reset");
        rst = 1'b0;

        word(0, S_OB, 6'd24);           // type at byte 2
        meta("w0", 8'h4F, 16'd29, 32'd1);
        word(1, S_NONE, 6'd24);
        word(2, S_NONE, 6'd24);
        word(3, S_NONE, 6'd24);         // prefix MSB at byte 7
        word(4, S_ADD, 6'd16);          // prefix split 1+2
        meta("w4", 8'h41, 16'd12, 32'd2);
        word(5, S_NONE, 6'd16);         // type byte at byte 7
        chk("w5 msgCount", 64'(bus.msgCount), 64'd2);
        word(6, S_DEL, 6'd0);           // deferred strobe; body ends on byte 7
        meta("w6", 8'h44, 16'd9, 32'd3);
        word(7, S_OTH, 6'd24);          // prefix at byte 0, unknown type 'X'
        meta("w7", 8'h58, 16'd12, 32'd4);
        word(8, S_NONE, 6'd24);         // prefix at bytes 6,7
        word(9, S_EXE, 6'd8);           // split 2+1
        meta("w9", 8'h45, 16'd14, 32'd5);
        word(10, S_NONE, 6'd8);         // length bytes at 6,7; type in next word

        for (int i = 0; i < 3; i++) begin
            step(64'hDEAD_BEEF_0000_4F00, 1'b0);
            chk($sformatf("idle%0d dataOutValid", i), 64'(bus.dataOutValid), 64'd0);
            chk($sformatf("idle%0d strobes", i), 64'(strobes()), 64'(S_NONE));
            chk($sformatf("idle%0d dataOut", i), bus.dataOut, wd[10]);
        end

        word(11, S_ADD, 6'd8);
        meta("w11", 8'h41, 16'd9, 32'd6);
        word(12, S_OB, 6'd32);
        meta("w12", 8'h4F, 16'd20, 32'd7);
        word(13, S_NONE, 6'd32);
        word(14, S_NONE, 6'd32);
        chk("w14 errLength", 64'(bus.errLength), 64'd0);
        word(15, S_NONE, 6'd32);        // L = 5 completes here
        chk("w15 errLength", 64'(bus.errLength), 64'd1);
        word(16, S_NONE, 6'd32);
        word(17, S_NONE, 6'd32);
        chk("w17 errLength", 64'(bus.errLength), 64'd1);
        chk("w17 msgCount", 64'(bus.msgCount), 64'd7);

        // Reset clears the error and framing resumes at the next word.
        rst = 1'b1;
        step(64'h0000_0000_0041_0900, 1'b1);
        chk_reset("rst2");
        rst = 1'b0;

        // L=11 'E' at byte 2; next message 'A' L=12 has its type at byte 7.
        step(64'hAAAA_AAAA_AA45_0B00, 1'b1);
        chk("A strobes", 64'(strobes()), 64'(S_EXE));
        chk("A trackerOut", 64'(bus.trackerOut), 64'd24);
        meta("A", 8'h45, 16'd11, 32'd1);
        step(64'h410C_00BB_BBBB_BBBB, 1'b1);
        chk("A2 strobes", 64'(strobes()), 64'(S_NONE));

        // Reset with a strobe pending: it must be dropped.
        rst = 1'b1;
        step(64'h0000_0000_0000_0000, 1'b0);
        chk_reset("rst3");
        rst = 1'b0;

        step(64'hCCCC_CCCC_CC44_0900, 1'b1);
        chk("B strobes", 64'(strobes()), 64'(S_DEL));
        chk("B trackerOut", 64'(bus.trackerOut), 64'd24);
        chk("B dataOut", bus.dataOut, 64'hCCCC_CCCC_CC44_0900);
        meta("B", 8'h44, 16'd9, 32'd1);

        step(64'd0, 1'b0);
        chk("end strobes", 64'(strobes()), 64'(S_NONE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/itch_message_dispatcher.md
# itch_message_dispatcher

Front-end framing stage of the ITCH parser: consumes the raw 64-bit stream of back-to-back length-prefixed ITCH messages, extracts each message's length and type byte, and fires a one-cycle start strobe plus a bit-offset tracker to the matching per-message parser (order book state, add, execute, delete, other). It re-presents the data word to the parsers with a fixed one-word delay so that every strobe coincides with the word holding the first body byte.

## Interface
- MIN_LEN, 9, smallest legal length-field value (type byte + body); anything below is a framing error
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- dataIn  in  64  stream word; stream byte k of the word sits at dataIn[8k+7:8k]
- dataValid  in  1  dataIn carries a word this cycle; no backpressure
- dataOut  out  64  dataIn delayed by exactly one accepted word
- dataOutValid  out  1  dataOut updated this cycle
- startOrderBookState / startAddOrder / startExecuted / startDelete / startOther  out  1 each  one-cycle start strobes, types 'O' 0x4F, 'A' 0x41, 'E' 0x45, 'D' 0x44, any other
- trackerOut  out  6  bit offset (8 × byte index) of the first body byte inside dataOut; valid with any strobe
- msgType  out  8  type byte of the last started message
- msgLength  out  16  length field of the last started message
- msgCount  out  32  number of messages started since reset, wraps
- errLength  out  1  sticky framing error

## Operation
- Message layout: 2-byte big-endian length L (first byte = MSB), then type byte, then L−1 body bytes; next prefix follows immediately.
- Byte walker with byte pointer ptr (0..7) per word; states:
  - HDR: collect prefix bytes and type byte (hdrCnt 0..2). A header may straddle one word boundary.
  - BODY: skip bytesLeft body bytes (16-bit down-counter loaded with L−1 once the type byte is taken); when it reaches 0, return to HDR at the following byte.
  - ERR: entered when L < MIN_LEN; no further strobes until rst; dataOut/dataOutValid keep flowing.
- Because L ≥ 9, a word holds at most one body start; at most one strobe per cycle.
- On taking the type byte: latch msgType, msgLength, increment msgCount, and schedule a strobe for the word holding body byte 0 (same word, or next word if the type byte was byte 7), with trackerOut = 8 × its byte index.
- Words with dataValid = 0 are ignored; walker state and pending strobes hold.

## Timing
- Reset values: dataOut 0, dataOutValid 0, all strobes 0, trackerOut 0, msgType 0, msgLength 0, msgCount 0, errLength 0; walker in HDR with ptr 0, hdrCnt 0. The first word accepted after rst is treated as starting with a length prefix.
- Latency: dataOut/dataOutValid register the word one cycle after it is accepted. A strobe is asserted in the same cycle as dataOutValid for the word containing the first body byte.
- Strobes, trackerOut, msgType, msgLength and msgCount update together, all registered. trackerOut holds between strobes.
- rst mid-message: the partial message is discarded and any pending strobe is dropped.
- bytesLeft and ptr must handle a body ending exactly on byte 7 (next prefix at byte 0 of the next word) and a prefix split 1+2 or 2+1 across words.

## Structure
- Shared package itch_pkg: type-code constants (0x4F, 0x41, 0x45, 0x44), MIN_LEN default, and a dispatcher state enum (HDR, BODY, ERR).
- One natural sub-module: itch_type_decoder, which is combinational and maps a type byte to a one-hot start vector.

## Test plan
- Word0 bytes 00 1D 4F … (L = 29, 'O'): startOrderBookState = 1 one cycle after word0, with dataOut = word0 and trackerOut = 24; msgLength = 29, msgCount = 1.
- Second message follows immediately: prefix at word3 byte 7 and word4 byte 0, type 0x41 at word4 byte 1. Required: startAddOrder with dataOut = word4 and trackerOut = 16.
- Type byte at byte 7 of word N: no strobe with word N; the strobe appears with dataOut = word N+1 and trackerOut = 0.
- Type 0x58 ('X'), L = 12: startOther pulses, msgType = 0x58, and the following message is still framed correctly.
- L = 5: errLength = 1 and stays 1; no strobes afterwards; dataOut still tracks dataIn; rst clears errLength and resumes framing.
- dataValid low for 3 cycles inside a header split across two words: the strobe arrives one cycle after the completing word, with the correct trackerOut. Separately, rst asserted mid-body: all outputs return to their reset values, and the next word's bytes 0–1 are parsed as a length.
